// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and defaults for the UART frame parser
package uart_pkg;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    PAYLOAD,
    CHK,
    HOLD
  } state_t;

endpackage

// File: rtl/uart_frame_buf.sv
// rtl/uart_frame_buf.sv - payload RAM, one write port and one registered read port
module uart_frame_buf #(
  parameter int DBIT  = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DBIT-1:0] wr_data,
  input  logic [AW-1:0]   rd_addr,
  output logic [DBIT-1:0] rd_data
);

  logic [DBIT-1:0] mem_q [DEPTH];
  logic [DBIT-1:0] rd_data_q;

  // Storage is deliberately left out of reset; only the read register clears.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - pops RX FIFO bytes, parses SOF/LEN/payload/XOR frames, holds until ack
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int              DBIT    = 8,
  parameter int              MAX_LEN = 16,
  parameter logic [DBIT-1:0] SOF     = DBIT'(SOF_DEFAULT),
  parameter int              TIMEOUT = 100000,
  localparam int             AW      = $clog2(MAX_LEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DBIT-1:0] r_data,
  input  logic            rx_empty,
  output logic            rd_uart,
  output logic            frm_valid,
  output logic [7:0]      frm_len,
  input  logic [AW-1:0]   frm_rd_addr,
  output logic [DBIT-1:0] frm_rd_data,
  input  logic            frm_ack,
  output logic            crc_err,
  output logic            len_err,
  output logic            to_err
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  state_t          state_q;
  logic [DBIT-1:0] chk_q;
  byte_t           idx_q;
  byte_t           frm_len_q;
  logic [TW-1:0]   timer_q;
  logic            frm_valid_q, crc_err_q, len_err_q, to_err_q;

  logic            pop, timing, wr_en;
  logic [TW-1:0]   timer_d;

  assign pop     = ~rx_empty & (state_q != HOLD);
  assign timing  = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHK);
  assign wr_en   = pop && (state_q == PAYLOAD);
  assign timer_d = timer_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      chk_q       <= '0;
      idx_q       <= '0;
      frm_len_q   <= '0;
      timer_q     <= '0;
      frm_valid_q <= 1'b0;
      crc_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
      to_err_q    <= 1'b0;
    end else begin
      crc_err_q <= 1'b0;
      len_err_q <= 1'b0;
      to_err_q  <= 1'b0;
      if (timing) timer_q <= pop ? '0 : timer_d;

      case (state_q)
        IDLE: if (pop && r_data == SOF) begin
          state_q <= LEN;
          chk_q   <= '0;
          timer_q <= '0;
        end
        LEN: if (pop) begin
          chk_q <= r_data;
          if (r_data > DBIT'(MAX_LEN)) begin
            len_err_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            frm_len_q <= 8'(r_data);
            idx_q     <= '0;
            state_q   <= (r_data == '0) ? CHK : PAYLOAD;
          end
        end
        PAYLOAD: if (pop) begin
          chk_q <= chk_q ^ r_data;
          idx_q <= idx_q + 8'd1;
          if (idx_q == frm_len_q - 8'd1) state_q <= CHK;
        end
        CHK: if (pop) begin
          if (r_data == chk_q) begin
            state_q     <= HOLD;
            frm_valid_q <= 1'b1;
          end else begin
            crc_err_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        HOLD: if (frm_ack) begin
          state_q     <= IDLE;
          frm_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase

      // A pop in the expiry cycle wins, so this only fires on idle cycles.
      if (timing && !pop && timer_d == TW'(TIMEOUT - 1)) begin
        to_err_q <= 1'b1;
        state_q  <= IDLE;
      end
    end
  end

  uart_frame_buf #(
    .DBIT  (DBIT),
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (idx_q[AW-1:0]),
    .wr_data (r_data),
    .rd_addr (frm_rd_addr),
    .rd_data (frm_rd_data)
  );

  assign rd_uart   = pop;
  assign frm_valid = frm_valid_q;
  assign frm_len   = frm_len_q;
  assign crc_err   = crc_err_q;
  assign len_err   = len_err_q;
  assign to_err    = to_err_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - directed self-checking bench for uart_frame_parser
module tb_uart_frame_parser;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       rx_empty = 1'b1;
  logic       rd_uart;
  logic       frm_valid;
  logic [7:0] frm_len;
  logic [3:0] frm_rd_addr = 4'd0;
  logic [7:0] frm_rd_data;
  logic       frm_ack = 1'b0;
  logic       crc_err, len_err, to_err;

  int tests = 0;
  int fails = 0;
  int n_crc = 0, n_len = 0, n_to = 0;

  logic [7:0] fifo[$];
  logic       pop_now = 1'b0;

  uart_frame_parser #(.DBIT(8), .MAX_LEN(16), .SOF(8'hA5), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .r_data(r_data), .rx_empty(rx_empty), .rd_uart(rd_uart),
    .frm_valid(frm_valid), .frm_len(frm_len), .frm_rd_addr(frm_rd_addr),
    .frm_rd_data(frm_rd_data), .frm_ack(frm_ack),
    .crc_err(crc_err), .len_err(len_err), .to_err(to_err)
  );

  always #5 clk = ~clk;

  // First-word-fall-through FIFO model: head changes on the falling edge only.
  always @(negedge clk) begin
    if (pop_now && fifo.size() > 0) fifo.delete(0);
    rx_empty = (fifo.size() == 0);
    r_data   = rx_empty ? 8'h00 : fifo[0];
    #1 pop_now = rd_uart;
  end

  always @(negedge clk) begin
    n_crc += int'(crc_err);
    n_len += int'(len_err);
    n_to  += int'(to_err);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic wait_valid(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (frm_valid === 1'b1) begin n = i; break; end
    end
  endtask

  task automatic ack();
    frm_ack = 1'b1; tick(); frm_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(3);
    tests++; if (frm_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", frm_valid); end
    tests++; if (frm_len !== 8'd0) begin fails++; $display("FAIL reset_len got %0d want 0", frm_len); end
    tests++; if (frm_rd_data !== 8'd0) begin fails++; $display("FAIL reset_rd_data got %h want 00", frm_rd_data); end
    tests++; if ({crc_err, len_err, to_err} !== 3'b000) begin fails++; $display("FAIL reset_errs got %b want 000", {crc_err, len_err, to_err}); end
    reset = 1'b0; tick();
    tests++; if (rd_uart !== 1'b0) begin fails++; $display("FAIL reset_rd_uart got %b want 0", rd_uart); end
  endtask

  task automatic test_good_frame();
    int n, e0;
    logic [7:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
    e0 = n_crc + n_len + n_to;
    push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h03);
    wait_valid(20, n);
    tests++; if (n !== 6) begin fails++; $display("FAIL good_latency got %0d want 6", n); end
    tests++; if (frm_len !== 8'd3) begin fails++; $display("FAIL good_len got %0d want 3", frm_len); end
    for (int i = 0; i < 3; i++) begin
      frm_rd_addr = 4'(i); tick();
      tests++; if (frm_rd_data !== exp_d[i]) begin fails++; $display("FAIL good_data[%0d] got %h want %h", i, frm_rd_data, exp_d[i]); end
    end
    tests++; if (n_crc + n_len + n_to !== e0) begin fails++; $display("FAIL good_errs got %0d want %0d", n_crc + n_len + n_to, e0); end
    ack();
    tests++; if (frm_valid !== 1'b0) begin fails++; $display("FAIL good_ack got %b want 0", frm_valid); end
  endtask

  task automatic test_crc_err();
    int c0 = n_crc, o0 = n_len + n_to;
    push(8'hA5); push(8'h02); push(8'h10); push(8'h20); push(8'hFF);
    tick(8);
    tests++; if (n_crc - c0 !== 1) begin fails++; $display("FAIL crc_pulses got %0d want 1", n_crc - c0); end
    tests++; if (n_len + n_to !== o0) begin fails++; $display("FAIL crc_other got %0d want %0d", n_len + n_to, o0); end
    tests++; if (frm_valid !== 1'b0) begin fails++; $display("FAIL crc_valid got %b want 0", frm_valid); end
  endtask

  task automatic test_zero_len();
    int n, e0 = n_crc + n_len + n_to;
    push(8'h00); push(8'hFF); push(8'h5A); push(8'hA5); push(8'h00); push(8'h00);
    wait_valid(20, n);
    tests++; if (n !== 6) begin fails++; $display("FAIL zero_latency got %0d want 6", n); end
    tests++; if (frm_len !== 8'd0) begin fails++; $display("FAIL zero_len got %0d want 0", frm_len); end
    tests++; if (n_crc + n_len + n_to !== e0) begin fails++; $display("FAIL zero_errs got %0d want %0d", n_crc + n_len + n_to, e0); end
    ack();
  endtask

  task automatic test_len_err();
    int n, l0 = n_len;
    push(8'hA5); push(8'h11); push(8'hA5); push(8'h01); push(8'h7E); push(8'h7F);
    wait_valid(20, n);
    tests++; if (n_len - l0 !== 1) begin fails++; $display("FAIL len_pulses got %0d want 1", n_len - l0); end
    tests++; if (n !== 6) begin fails++; $display("FAIL len_next_latency got %0d want 6", n); end
    tests++; if (frm_len !== 8'd1) begin fails++; $display("FAIL len_next_len got %0d want 1", frm_len); end
    frm_rd_addr = 4'd0; tick();
    tests++; if (frm_rd_data !== 8'h7E) begin fails++; $display("FAIL len_next_data got %h want 7e", frm_rd_data); end
    ack();
  endtask

  task automatic test_timeout();
    int t0 = n_to, first = -1, n;
    push(8'hA5); push(8'h02); push(8'h11);
    tick(3);
    for (int k = 1; k <= TO + 2; k++) begin
      tick();
      if (to_err === 1'b1 && first < 0) first = k;
    end
    tests++; if (first !== TO - 1) begin fails++; $display("FAIL to_position got %0d want %0d", first, TO - 1); end
    tests++; if (n_to - t0 !== 1) begin fails++; $display("FAIL to_pulses got %0d want 1", n_to - t0); end
    t0 = n_to;
    push(8'hA5); push(8'h02); push(8'h11);
    tick(3);
    tick(TO - 2);
    push(8'h22); push(8'h31);
    wait_valid(10, n);
    tests++; if (n_to - t0 !== 0) begin fails++; $display("FAIL to_prevent got %0d want 0", n_to - t0); end
    tests++; if (frm_valid !== 1'b1) begin fails++; $display("FAIL to_prevent_valid got %b want 1", frm_valid); end
    ack();
  endtask

  task automatic test_back_to_back();
    int n;
    push(8'hA5); push(8'h02); push(8'hAA); push(8'hBB); push(8'h13);
    push(8'hA5); push(8'h01); push(8'hC3); push(8'hC2);
    wait_valid(20, n);
    tests++; if (n !== 5) begin fails++; $display("FAIL b2b_latency got %0d want 5", n); end
    for (int i = 0; i < 2; i++) begin
      frm_rd_addr = 4'(i); tick();
      tests++; if (rd_uart !== 1'b0) begin fails++; $display("FAIL b2b_stall got %b want 0", rd_uart); end
      tests++; if (frm_rd_data !== (i == 0 ? 8'hAA : 8'hBB)) begin fails++; $display("FAIL b2b_data1[%0d] got %h", i, frm_rd_data); end
    end
    tests++; if (fifo.size() !== 4) begin fails++; $display("FAIL b2b_fifo got %0d want 4", fifo.size()); end
    ack();
    wait_valid(20, n);
    tests++; if (frm_len !== 8'd1) begin fails++; $display("FAIL b2b_len2 got %0d want 1", frm_len); end
    frm_rd_addr = 4'd0; tick();
    tests++; if (frm_rd_data !== 8'hC3) begin fails++; $display("FAIL b2b_data2 got %h want c3", frm_rd_data); end
    ack();
  endtask

  task automatic test_reset_mid();
    int n, e0 = n_crc + n_len + n_to;
    push(8'hA5); push(8'h04); push(8'h01); push(8'h02);
    tick(4);
    reset = 1'b1; tick(); reset = 1'b0;
    tick(TO + 5);
    tests++; if (n_crc + n_len + n_to !== e0) begin fails++; $display("FAIL rst_mid_errs got %0d want %0d", n_crc + n_len + n_to, e0); end
    tests++; if (frm_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid got %b want 0", frm_valid); end
    push(8'hA5); push(8'h01); push(8'h55); push(8'h54);
    wait_valid(20, n);
    tests++; if (n !== 4) begin fails++; $display("FAIL rst_mid_next got %0d want 4", n); end
    frm_rd_addr = 4'd0; tick();
    tests++; if (frm_rd_data !== 8'h55) begin fails++; $display("FAIL rst_mid_data got %h want 55", frm_rd_data); end
    ack();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_crc_err();
    test_zero_len();
    test_len_err();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
